// File: rtl/retire_trace_buf_pkg.sv
// Shared types and constants for the retire commit-trace unit.
// Holds the trace record layout, the drain FSM states and the small helpers both RTL files use.
package retire_trace_buf_pkg;

    localparam int         N_ENTRY_ROB = 32;
    localparam int         TRACE_XLEN  = 64;
    localparam logic [4:0] ZERO_REG    = 5'd31;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_SEEN = 2'd1,
        DRAINED   = 2'd2
    } trace_state_e;

    typedef struct packed {
        logic [4:0]            wr_idx;
        logic [TRACE_XLEN-1:0] value;
        logic [63:0]           npc;
        logic                  halt;
    } trace_rec_t;

    // Smaller of a requested push count and the free slot count, both widened to 32 bits.
    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        int unsigned r;
        if (a < b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/retire_trace_buf_if.sv
// Consumer-facing trace port: the FIFO head plus the consumer's ready.
// The trace unit drives it through the master modport; the consumer uses slave.
interface retire_trace_buf_if #(
    parameter int XLEN = 64
);
    logic            trace_valid;
    logic            trace_ready;
    logic [4:0]      trace_wr_idx;
    logic [XLEN-1:0] trace_wr_value;
    logic [63:0]     trace_NPC;
    logic            trace_halt;

    modport master (
        output trace_valid, trace_wr_idx, trace_wr_value, trace_NPC, trace_halt,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_wr_idx, trace_wr_value, trace_NPC, trace_halt,
        output trace_ready
    );
endinterface

// File: rtl/retire_trace_buf_fifo.sv
// Multi-push, single-pop record FIFO. Accepts the oldest pushes that fit,
// counting a same-cycle pop as freeing a slot, and flags the cycle when pushes are dropped.
module retire_trace_buf_fifo
    import retire_trace_buf_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int N_PUSH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int CNT_W = $clog2(N_PUSH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CNT_W-1:0]        push_cnt,
    input  trace_rec_t [N_PUSH-1:0] push_data,
    input  logic                    pop,
    output trace_rec_t              head,
    output logic                    empty,
    output logic [OCC_W-1:0]        occupancy,
    output logic                    drop
);

    trace_rec_t       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             pop_ok_s;
    int unsigned      free_s;
    int unsigned      accept_s;

    // Slot accounting: free space includes the slot released by a same-cycle pop.
    always_comb begin
        pop_ok_s = pop && (occ_r != '0);
        free_s   = 32'(DEPTH) - 32'(occ_r) + 32'(pop_ok_s);
        accept_s = min_u(32'(push_cnt), free_s);
        drop     = 32'(push_cnt) > free_s;
    end

    // Pointer and occupancy registers; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(accept_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_ok_s);
            occ_r    <= occ_r + OCC_W'(accept_s) - OCC_W'(pop_ok_s);
        end
    end

    // Record storage; only accepted lanes are written, oldest at the write pointer.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_PUSH; k++) begin
            if (!rst && (32'(k) < accept_s)) begin
                mem_r[wr_ptr_r + PTR_W'(k)] <= push_data[k];
            end else begin
                mem_r[wr_ptr_r + PTR_W'(k)] <= mem_r[wr_ptr_r + PTR_W'(k)];
            end
        end
    end

    assign head      = mem_r[rd_ptr_r];
    assign empty     = (occ_r == '0);
    assign occupancy = occ_r;

endmodule

// File: rtl/retire_trace_buf.sv
// Commit-trace unit for the N-wide retire stage: captures retirements, resolves their
// values from the physical RF a cycle later, and queues them in program order for draining.
module retire_trace_buf
    import retire_trace_buf_pkg::*;
#(
    parameter int N_RETIRE = 2,
    parameter int N_PREG   = N_ENTRY_ROB + 33,
    parameter int PREG_W   = $clog2(N_PREG),
    parameter int XLEN     = TRACE_XLEN,
    parameter int DEPTH    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_RETIRE-1:0]               retire_valid,
    input  logic [N_RETIRE-1:0][4:0]          retire_wr_idx,
    input  logic [N_RETIRE-1:0][PREG_W-1:0]   retire_tag,
    input  logic [N_RETIRE-1:0][63:0]         retire_NPC,
    input  logic [N_RETIRE-1:0]               retire_halt,
    input  logic [N_PREG-1:0][XLEN-1:0]       value_RF,
    input  logic [31:0][PREG_W-1:0]           arch_tag,
    retire_trace_buf_if.master                trace,
    output logic [31:0][XLEN-1:0]             arch_rf_value,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy,
    output logic                              overflow,
    output logic                              halted
);

    localparam int CNT_W = $clog2(N_RETIRE + 1);

    trace_state_e                      state_r;
    trace_state_e                      state_nxt_s;
    logic [N_RETIRE-1:0]               s1_valid_r;
    logic [N_RETIRE-1:0][4:0]          s1_wr_idx_r;
    logic [N_RETIRE-1:0][PREG_W-1:0]   s1_tag_r;
    logic [N_RETIRE-1:0][63:0]         s1_npc_r;
    logic [N_RETIRE-1:0]               s1_halt_r;
    logic [N_RETIRE-1:0]               cap_valid_s;
    logic                              lane_stop_s;
    logic                              s1_has_halt_s;
    trace_rec_t [N_RETIRE-1:0]         lane_rec_s;
    trace_rec_t [N_RETIRE-1:0]         push_data_s;
    logic [CNT_W-1:0]                  lane_cnt_s;
    logic [CNT_W-1:0]                  push_cnt_s;
    logic                              s2_halt_s;
    logic                              pop_s;
    logic                              fifo_empty_s;
    logic                              fifo_drop_s;
    trace_rec_t                        head_s;
    logic                              overflow_r;
    logic                              halted_r;
    logic [PREG_W-1:0]                 unused_s;

    function automatic logic [XLEN-1:0] read_rf(input logic [N_PREG-1:0][XLEN-1:0] rf,
                                                input logic [PREG_W-1:0]           tag);
        logic [XLEN-1:0] val;
        if (32'(tag) < 32'(N_PREG)) begin
            val = rf[tag];
        end else begin
            val = '0;
        end
        return val;
    endfunction

    assign s1_has_halt_s = |(s1_valid_r & s1_halt_r);

    // Capture mask: nothing once a halt is in flight or seen; otherwise stop after the first halting lane.
    always_comb begin
        cap_valid_s = '0;
        lane_stop_s = 1'b0;
        if (state_r == RUN && !s1_has_halt_s) begin
            for (int i = 0; i < N_RETIRE; i++) begin
                if (retire_valid[i] && !lane_stop_s) begin
                    cap_valid_s[i] = 1'b1;
                    lane_stop_s    = retire_halt[i];
                end else begin
                    cap_valid_s[i] = 1'b0;
                end
            end
        end else begin
            cap_valid_s = '0;
        end
    end

    // S1 capture register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= '0;
            s1_wr_idx_r <= '0;
            s1_tag_r    <= '0;
            s1_npc_r    <= '0;
            s1_halt_r   <= '0;
        end else begin
            s1_valid_r  <= cap_valid_s;
            s1_wr_idx_r <= retire_wr_idx;
            s1_tag_r    <= retire_tag;
            s1_npc_r    <= retire_NPC;
            s1_halt_r   <= retire_halt;
        end
    end

    // S2 record build: the value comes from the RF now that the producer has written it.
    always_comb begin
        lane_rec_s = '0;
        for (int i = 0; i < N_RETIRE; i++) begin
            lane_rec_s[i].wr_idx = s1_wr_idx_r[i];
            lane_rec_s[i].npc    = s1_npc_r[i];
            lane_rec_s[i].halt   = s1_halt_r[i];
            if (s1_wr_idx_r[i] == ZERO_REG) begin
                lane_rec_s[i].value = '0;
            end else begin
                lane_rec_s[i].value = read_rf(value_RF, s1_tag_r[i]);
            end
        end
    end

    // Compaction: walk youngest to oldest, shifting each valid lane in at slot 0.
    always_comb begin
        push_data_s = '0;
        lane_cnt_s  = '0;
        s2_halt_s   = 1'b0;
        for (int i = N_RETIRE - 1; i >= 0; i--) begin
            if (s1_valid_r[i]) begin
                push_data_s = {push_data_s[N_RETIRE-2:0], lane_rec_s[i]};
                lane_cnt_s  = lane_cnt_s + CNT_W'(1'b1);
                s2_halt_s   = s2_halt_s | s1_halt_r[i];
            end else begin
                push_data_s = push_data_s;
            end
        end
    end

    assign push_cnt_s = (state_r == RUN) ? lane_cnt_s : '0;
    assign pop_s      = !fifo_empty_s && trace.trace_ready;

    retire_trace_buf_fifo #(
        .DEPTH  (DEPTH),
        .N_PUSH (N_RETIRE)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_cnt  (push_cnt_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (fifo_empty_s),
        .occupancy (occupancy),
        .drop      (fifo_drop_s)
    );

    // Drain FSM next state; DRAINED is entered on the edge that empties the FIFO.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (s2_halt_s) begin
                    state_nxt_s = HALT_SEEN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HALT_SEEN: begin
                if (fifo_empty_s || (occupancy == 1 && pop_s)) begin
                    state_nxt_s = DRAINED;
                end else begin
                    state_nxt_s = HALT_SEEN;
                end
            end
            DRAINED: state_nxt_s = DRAINED;
            default: state_nxt_s = RUN;
        endcase
    end

    // State, sticky overflow and halted registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            overflow_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            overflow_r <= overflow_r | fifo_drop_s;
            halted_r   <= (state_nxt_s == DRAINED);
        end
    end

    assign overflow = overflow_r;
    assign halted   = halted_r;

    // Head presentation straight from FIFO storage, zeroed when empty.
    always_comb begin
        if (!fifo_empty_s) begin
            trace.trace_valid    = 1'b1;
            trace.trace_wr_idx   = head_s.wr_idx;
            trace.trace_wr_value = head_s.value;
            trace.trace_NPC      = head_s.npc;
            trace.trace_halt     = head_s.halt;
        end else begin
            trace.trace_valid    = 1'b0;
            trace.trace_wr_idx   = '0;
            trace.trace_wr_value = '0;
            trace.trace_NPC      = '0;
            trace.trace_halt     = 1'b0;
        end
    end

    // Architectural readout; the zero register always reads 0.
    always_comb begin
        arch_rf_value = '0;
        for (int i = 0; i < 31; i++) begin
            arch_rf_value[i] = read_rf(value_RF, arch_tag[i]);
        end
    end

    assign unused_s = arch_tag[31];

endmodule

// File: tb/tb_retire_trace_buf.sv
// Directed bench for retire_trace_buf: latency, compaction, overflow, halt/drain and reset.
// Expected values are hand-derived from the stimulus; each comparison is an immediate assertion.
module tb_retire_trace_buf;
    import retire_trace_buf_pkg::*;

    localparam int NR = 2;
    localparam int NP = 65;
    localparam int PW = 7;
    localparam int XL = 64;
    localparam int DP = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NR-1:0]           retire_valid;
    logic [NR-1:0][4:0]      retire_wr_idx;
    logic [NR-1:0][PW-1:0]   retire_tag;
    logic [NR-1:0][63:0]     retire_NPC;
    logic [NR-1:0]           retire_halt;
    logic [NP-1:0][XL-1:0]   value_RF;
    logic [31:0][PW-1:0]     arch_tag;
    logic [31:0][XL-1:0]     arch_rf_value;
    logic [4:0]              occupancy;
    logic                    overflow;
    logic                    halted;
    int                      vectors = 0;
    int                      miscompares = 0;

    retire_trace_buf_if #(.XLEN(XL)) trace_bus ();

    retire_trace_buf #(
        .N_RETIRE (NR),
        .N_PREG   (NP),
        .PREG_W   (PW),
        .XLEN     (XL),
        .DEPTH    (DP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .retire_valid  (retire_valid),
        .retire_wr_idx (retire_wr_idx),
        .retire_tag    (retire_tag),
        .retire_NPC    (retire_NPC),
        .retire_halt   (retire_halt),
        .value_RF      (value_RF),
        .arch_tag      (arch_tag),
        .trace         (trace_bus),
        .arch_rf_value (arch_rf_value),
        .occupancy     (occupancy),
        .overflow      (overflow),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rf_model(input int i);
        logic [63:0] v;
        if (i == 40) begin
            v = 64'h55;
        end else begin
            v = 64'hA5A5_0000_0000_0000 | 64'(i);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_retire();
        retire_valid  = '0;
        retire_wr_idx = '0;
        retire_tag    = '0;
        retire_NPC    = '0;
        retire_halt   = '0;
    endtask

    task automatic set_lane(input bit l, input logic [4:0] idx, input logic [PW-1:0] tag,
                            input logic [63:0] npc, input logic halt);
        retire_valid[l]  = 1'b1;
        retire_wr_idx[l] = idx;
        retire_tag[l]    = tag;
        retire_NPC[l]    = npc;
        retire_halt[l]   = halt;
    endtask

    // Two-wide retire number v: lane0 -> r1, lane1 -> r2, tags 20+2v(+1), NPC 0x1000+8v(+4).
    task automatic set_pair(input int v);
        set_lane(1'b0, 5'd1, PW'(20 + 2 * v), 64'h1000 + 64'(8 * v), 1'b0);
        set_lane(1'b1, 5'd2, PW'(21 + 2 * v), 64'h1004 + 64'(8 * v), 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NP; i++) value_RF[i] = rf_model(i);
        for (int i = 0; i < 32; i++) arch_tag[i] = PW'(i);
        clear_retire();
        trace_bus.trace_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 64'(trace_bus.trace_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_npc", trace_bus.trace_NPC, 64'd0);

        // 1: single retire, two-cycle latency
        trace_bus.trace_ready = 1'b1;
        set_lane(1'b0, 5'd3, 7'd40, 64'h104, 1'b0);
        tick();
        clear_retire();
        chk("t1_early", 64'(trace_bus.trace_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(trace_bus.trace_valid), 64'd1);
        chk("t1_idx", 64'(trace_bus.trace_wr_idx), 64'd3);
        chk("t1_value", trace_bus.trace_wr_value, 64'h55);
        chk("t1_npc", trace_bus.trace_NPC, 64'h104);
        chk("t1_occ", 64'(occupancy), 64'd1);
        tick();
        chk("t1_pop_occ", 64'(occupancy), 64'd0);
        chk("t1_pop_valid", 64'(trace_bus.trace_valid), 64'd0);

        // 2: both lanes, lane1 writes the zero register
        trace_bus.trace_ready = 1'b0;
        set_lane(1'b0, 5'd7, 7'd10, 64'h200, 1'b0);
        set_lane(1'b1, 5'd31, 7'd11, 64'h204, 1'b0);
        tick();
        clear_retire();
        tick();
        chk("t2_occ", 64'(occupancy), 64'd2);
        chk("t2_idx0", 64'(trace_bus.trace_wr_idx), 64'd7);
        chk("t2_val0", trace_bus.trace_wr_value, 64'hA5A5_0000_0000_000A);
        chk("t2_npc0", trace_bus.trace_NPC, 64'h200);
        tick();
        chk("t2_stall_npc", trace_bus.trace_NPC, 64'h200);
        trace_bus.trace_ready = 1'b1;
        tick();
        chk("t2_idx1", 64'(trace_bus.trace_wr_idx), 64'd31);
        chk("t2_val1", trace_bus.trace_wr_value, 64'd0);
        chk("t2_npc1", trace_bus.trace_NPC, 64'h204);
        tick();
        chk("t2_occ_end", 64'(occupancy), 64'd0);

        // 3: nine two-wide retires into a stalled 16-entry FIFO
        trace_bus.trace_ready = 1'b0;
        for (int v = 0; v < 9; v++) begin
            set_pair(v);
            tick();
        end
        chk("t3_occ_full", 64'(occupancy), 64'd16);
        chk("t3_ovf_before", 64'(overflow), 64'd0);
        set_pair(9);
        tick();
        clear_retire();
        chk("t3_occ", 64'(occupancy), 64'd16);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_head_npc", trace_bus.trace_NPC, 64'h1000);

        // 5: pop and two-wide push while full -> one accepted, one dropped
        trace_bus.trace_ready = 1'b1;
        tick();
        chk("t5_occ", 64'(occupancy), 64'd16);
        for (int r = 1; r < 16; r++) begin
            int v;
            int lane;
            v    = r / 2;
            lane = r % 2;
            chk("t3_idx", 64'(trace_bus.trace_wr_idx), 64'(lane + 1));
            chk("t3_npc", trace_bus.trace_NPC, 64'h1000 + 64'(8 * v + 4 * lane));
            chk("t3_value", trace_bus.trace_wr_value, rf_model(20 + 2 * v + lane));
            tick();
        end
        chk("t5_last_npc", trace_bus.trace_NPC, 64'h1048);
        chk("t5_last_value", trace_bus.trace_wr_value, rf_model(38));
        tick();
        chk("t5_occ_end", 64'(occupancy), 64'd0);
        chk("t5_valid_end", 64'(trace_bus.trace_valid), 64'd0);

        // 6: reset mid-stream with occupancy 5 and a retire in flight
        trace_bus.trace_ready = 1'b0;
        set_pair(0);
        tick();
        set_pair(1);
        tick();
        clear_retire();
        set_lane(1'b0, 5'd9, 7'd30, 64'h500, 1'b0);
        tick();
        clear_retire();
        tick();
        chk("t6_occ5", 64'(occupancy), 64'd5);
        chk("t6_ovf_pre", 64'(overflow), 64'd1);
        set_lane(1'b0, 5'd9, 7'd30, 64'h600, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_retire();
        chk("t6_occ", 64'(occupancy), 64'd0);
        chk("t6_valid", 64'(trace_bus.trace_valid), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        chk("t6_halted", 64'(halted), 64'd0);
        tick();
        chk("t6_no_emit", 64'(trace_bus.trace_valid), 64'd0);
        chk("t6_occ_after", 64'(occupancy), 64'd0);

        // 4: halt on lane0 masks lane1; halted after the draining pop
        set_lane(1'b0, 5'd4, 7'd12, 64'h300, 1'b1);
        set_lane(1'b1, 5'd5, 7'd13, 64'h304, 1'b0);
        tick();
        clear_retire();
        tick();
        chk("t4_occ", 64'(occupancy), 64'd1);
        chk("t4_halt", 64'(trace_bus.trace_halt), 64'd1);
        chk("t4_npc", trace_bus.trace_NPC, 64'h300);
        chk("t4_value", trace_bus.trace_wr_value, rf_model(12));
        chk("t4_halted_early", 64'(halted), 64'd0);
        set_lane(1'b0, 5'd6, 7'd14, 64'h308, 1'b0);
        tick();
        clear_retire();
        tick();
        chk("t4_blocked", 64'(occupancy), 64'd1);
        chk("t4_halted_wait", 64'(halted), 64'd0);
        trace_bus.trace_ready = 1'b1;
        tick();
        chk("t4_occ_end", 64'(occupancy), 64'd0);
        chk("t4_halted", 64'(halted), 64'd1);
        tick();
        chk("t4_halted_hold", 64'(halted), 64'd1);

        // Architectural readout
        for (int i = 0; i < 31; i++) begin
            chk("arch_rf", arch_rf_value[i], rf_model(i));
        end
        chk("arch_r31", arch_rf_value[31], 64'd0);
        arch_tag[2] = 7'd40;
        #1;
        chk("arch_remap", arch_rf_value[2], 64'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
